fast_corner_collector: RTL and testbench



---
 rtl/fast_corner_collector_if.sv | 22 ++
 rtl/fast_corner_collector.sv | 125 ++++++++++++
 tb/tb_fast_corner_collector.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fast_corner_collector_if.sv
// Record stream from the corner collector to memory/DMA.
// Master drives valid/data/last, slave drives ready.
interface fast_corner_collector_if;
  logic        valid;
  logic        ready;
  logic        last;
  logic [32:0] data;

  modport master (
    output valid,
    output data,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  last,
    output ready
  );
endinterface

// File: rtl/fast_corner_collector.sv
// FAST corner collector: packs corners into a FWFT FIFO, closes each frame with a count marker.
// Optional macro FAST_COLLECT_SCORE_MIN_EN discards corners scoring below SCORE_MIN.
module fast_corner_collector #(
  parameter int         COL_NUM     = 640,
  parameter int         ROW_NUM     = 480,
  parameter int         FIFO_DEPTH  = 64,
  parameter int         MAX_CORNERS = 500,
  parameter logic [12:0] SCORE_MIN  = 13'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        iscorner,
  input  logic [9:0]  x_coord,
  input  logic [9:0]  y_coord,
  input  logic [12:0] score,
  fast_corner_collector_if.master m,
  output logic [15:0] drop_cnt,
  output logic        frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [9:0]    X_END   = 10'(COL_NUM - 1);
  localparam logic [9:0]    Y_END   = 10'(ROW_NUM - 1);
  localparam logic [12:0]   MAX_C   = 13'(MAX_CORNERS);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {
    WAIT_SOF,
    COLLECT
  } state_t;

  state_t state, state_nx;

  logic [33:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [12:0]   frame_cnt;

  logic sof, eof, active, score_ok;
  logic cand, room, cap_ok, acc, drop, mark;
  logic wr, rd;
  logic [33:0] wdata;

`ifdef FAST_COLLECT_SCORE_MIN_EN
  assign score_ok = (score >= SCORE_MIN);
`else
  logic unused_score_min;
  assign unused_score_min = &{1'b0, SCORE_MIN};
  assign score_ok = 1'b1;
`endif

  assign sof = ce & (x_coord == 10'd0) & (y_coord == 10'd0);
  assign eof = ce & (x_coord == X_END) & (y_coord == Y_END);

  always_comb begin
    state_nx = state;
    active   = 1'b0;
    unique case (state)
      WAIT_SOF: begin
        if (sof) begin
          active   = 1'b1;
          state_nx = eof ? WAIT_SOF : COLLECT;
        end
      end
      COLLECT: begin
        active = ce;
        if (eof) state_nx = WAIT_SOF;
      end
    endcase
  end

  // one slot always stays free for the end-of-frame marker
  assign room   = (count <= DEPTH_C - CW'(2));
  assign cap_ok = (frame_cnt < MAX_C);
  assign cand   = active & iscorner & ~eof & score_ok;
  assign acc    = cand & room & cap_ok;
  assign drop   = cand & ~(room & cap_ok);

  assign rd   = m.valid & m.ready;
  assign mark = active & eof & ((count != DEPTH_C) | rd);
  assign wr   = acc | mark;

  assign wdata = mark ? {1'b1, 10'h3FF, 10'h3FF, frame_cnt}
                      : {1'b0, y_coord, x_coord, score};

  assign m.valid = (count != '0);
  assign m.data  = m.valid ? mem[rd_ptr][32:0] : '0;
  assign m.last  = m.valid & mem[rd_ptr][33];

  always_ff @(posedge clk) begin
    if (rst) state <= WAIT_SOF;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= mark;
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr, rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (active & eof)  frame_cnt <= '0;
      else if (acc)      frame_cnt <= frame_cnt + 13'd1;
      if (drop && drop_cnt != 16'hFFFF)
        drop_cnt <= drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fast_corner_collector.sv
// Directed bench for fast_corner_collector on a reduced 16x8 frame.
// Two instances: default cap (A) and MAX_CORNERS=3 (B).
module tb_fast_corner_collector;

  localparam int COLS = 16;
  localparam int ROWS = 8;
  localparam int NPIX = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        iscorner;
  logic [9:0]  x_coord, y_coord;
  logic [12:0] score;
  logic [15:0] drop_a, drop_b;
  logic        fd_a, fd_b;

  fast_corner_collector_if ifa ();
  fast_corner_collector_if ifb ();

  fast_corner_collector #(
    .COL_NUM(COLS), .ROW_NUM(ROWS), .FIFO_DEPTH(64),
    .MAX_CORNERS(500), .SCORE_MIN(13'd50)
  ) dut_a (
    .clk(clk), .rst(rst), .ce(ce), .iscorner(iscorner),
    .x_coord(x_coord), .y_coord(y_coord), .score(score),
    .m(ifa.master), .drop_cnt(drop_a), .frame_done(fd_a)
  );

  fast_corner_collector #(
    .COL_NUM(COLS), .ROW_NUM(ROWS), .FIFO_DEPTH(64),
    .MAX_CORNERS(3), .SCORE_MIN(13'd50)
  ) dut_b (
    .clk(clk), .rst(rst), .ce(ce), .iscorner(iscorner),
    .x_coord(x_coord), .y_coord(y_coord), .score(score),
    .m(ifb.master), .drop_cnt(drop_b), .frame_done(fd_b)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int fda_n  = 0;
  int fdb_n  = 0;

  logic [33:0] qa[$];
  logic [33:0] qb[$];
  logic [33:0] eq[$];
  bit          cmap[NPIX];
  logic [12:0] smap[NPIX];

  always @(negedge clk) begin
    if (ifa.valid && ifa.ready) qa.push_back({ifa.last, ifa.data});
    if (ifb.valid && ifb.ready) qb.push_back({ifb.last, ifb.data});
    if (fd_a) fda_n++;
    if (fd_b) fdb_n++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] rec(input int x, input int y, input int s);
    return {1'b0, 10'(y), 10'(x), 13'(s)};
  endfunction

  function automatic logic [33:0] mk(input int n);
    return {1'b1, 10'h3FF, 10'h3FF, 13'(n)};
  endfunction

  task automatic cmp_q(input bit use_b, input string tag);
    int n;
    n = use_b ? qb.size() : qa.size();
    chk({tag, "_len"}, 64'(n), 64'(eq.size()));
    for (int i = 0; i < n && i < eq.size(); i++)
      chk($sformatf("%s_%0d", tag, i), use_b ? qb[i] : qa[i], eq[i]);
  endtask

  task automatic clr_map();
    for (int i = 0; i < NPIX; i++) begin
      cmap[i] = 1'b0;
      smap[i] = '0;
    end
  endtask

  task automatic pix(input int i);
    ce       = 1'b1;
    x_coord  = 10'(i % COLS);
    y_coord  = 10'(i / COLS);
    iscorner = cmap[i];
    score    = smap[i];
    @(posedge clk); #1;
  endtask

  // ce low with a start-of-frame look-alike must be ignored
  task automatic idle();
    ce       = 1'b0;
    x_coord  = '0;
    y_coord  = '0;
    iscorner = 1'b1;
    score    = 13'd99;
    @(posedge clk); #1;
  endtask

  task automatic run(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      if (i % 5 == 3) idle();
      pix(i);
    end
    ce       = 1'b0;
    iscorner = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ce  = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    qa.delete();
    qb.delete();
    fda_n = 0;
    fdb_n = 0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (!ifa.valid && !ifb.valid) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("drain_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ce = 1'b0; iscorner = 1'b0;
    x_coord = '0; y_coord = '0; score = '0;
    ifa.ready = 1'b1;
    ifb.ready = 1'b1;
    clr_map();
    @(posedge clk); #1;
    do_reset();

    chk("rst_valid", 64'(ifa.valid), 64'd0);
    chk("rst_data",  64'(ifa.data),  64'd0);
    chk("rst_last",  64'(ifa.last),  64'd0);
    chk("rst_drop",  64'(drop_a),    64'd0);
    chk("rst_fd",    64'(fd_a),      64'd0);

    // corners before the first start-of-frame
    cmap[20] = 1'b1; smap[20] = 13'd33;
    cmap[40] = 1'b1; smap[40] = 13'd44;
    run(5, NPIX - 1);
    drain();
    chk("presof_len", 64'(qa.size()), 64'd0);
    chk("presof_fd",  64'(fda_n),     64'd0);

    // basic frame: (2,1) s100, (5,2) s7
    clr_map();
    cmap[18] = 1'b1; smap[18] = 13'd100;
    cmap[37] = 1'b1; smap[37] = 13'd7;
    run(0, NPIX - 1);
    chk("fd_hi", 64'(fd_a), 64'd1);
    @(posedge clk); #1;
    chk("fd_lo", 64'(fd_a), 64'd0);
    drain();
    eq = '{rec(2, 1, 100), rec(5, 2, 7), mk(2)};
    cmp_q(1'b0, "basic");
    chk("basic_fd_n", 64'(fda_n), 64'd1);
    chk("basic_drop", 64'(drop_a), 64'd0);

    // backpressure: 70 corners, ready low the whole frame
    do_reset();
    clr_map();
    for (int i = 0; i < 70; i++) begin
      cmap[i] = 1'b1;
      smap[i] = 13'(i + 1);
    end
    ifa.ready = 1'b0;
    run(0, NPIX - 1);
    @(posedge clk); #1;
    chk("bp_drop",  64'(drop_a),    64'd7);
    chk("bp_valid", 64'(ifa.valid), 64'd1);
    chk("bp_head",  64'(ifa.data),  64'(rec(0, 0, 1)));
    ifa.ready = 1'b1;
    drain();
    eq.delete();
    for (int i = 0; i < 63; i++) eq.push_back(rec(i % COLS, i / COLS, i + 1));
    eq.push_back(mk(63));
    cmp_q(1'b0, "bp");

    // per-frame cap on instance B
    do_reset();
    clr_map();
    for (int k = 0; k < 5; k++) begin
      int p;
      p = (k == 0) ? 3 : (k == 1) ? 17 : (k == 2) ? 30 : (k == 3) ? 50 : 90;
      cmap[p] = 1'b1;
      smap[p] = 13'(11 + k);
    end
    eq = '{rec(3, 0, 11), rec(1, 1, 12), rec(14, 1, 13), mk(3)};
    run(0, NPIX - 1);
    drain();
    cmp_q(1'b1, "cap1");
    chk("cap1_drop", 64'(drop_b), 64'd2);
    qb.delete();
    run(0, NPIX - 1);
    drain();
    cmp_q(1'b1, "cap2");
    chk("cap2_drop", 64'(drop_b), 64'd4);
    chk("cap_fd_n",  64'(fdb_n),  64'd2);

    // reset in the middle of a frame with 4 records queued
    do_reset();
    clr_map();
    cmap[2] = 1'b1; cmap[4] = 1'b1; cmap[6] = 1'b1; cmap[8] = 1'b1;
    cmap[25] = 1'b1; cmap[30] = 1'b1;
    ifa.ready = 1'b0;
    run(0, 20);
    chk("mid_valid_pre", 64'(ifa.valid), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_valid", 64'(ifa.valid), 64'd0);
    chk("mid_drop",  64'(drop_a),    64'd0);
    ifa.ready = 1'b1;
    run(21, NPIX - 1);
    drain();
    chk("mid_rest_len", 64'(qa.size()), 64'd0);
    chk("mid_rest_fd",  64'(fda_n),     64'd0);
    run(0, NPIX - 1);
    drain();
    eq = '{rec(2, 0, 0), rec(4, 0, 0), rec(6, 0, 0), rec(8, 0, 0),
           rec(9, 1, 0), rec(14, 1, 0), mk(6)};
    cmp_q(1'b0, "mid_next");

    // score threshold (only active with the macro)
    do_reset();
    clr_map();
    cmap[1] = 1'b1; smap[1] = 13'd10;
    cmap[2] = 1'b1; smap[2] = 13'd50;
    cmap[3] = 1'b1; smap[3] = 13'd49;
    cmap[4] = 1'b1; smap[4] = 13'd200;
    run(0, NPIX - 1);
    drain();
`ifdef FAST_COLLECT_SCORE_MIN_EN
    eq = '{rec(2, 0, 50), rec(4, 0, 200), mk(2)};
`else
    eq = '{rec(1, 0, 10), rec(2, 0, 50), rec(3, 0, 49), rec(4, 0, 200), mk(4)};
`endif
    cmp_q(1'b0, "smin");
    chk("smin_drop", 64'(drop_a), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
